// File: rtl/prio_vectored_intc.sv
// Prioritised, vectored interrupt controller with a nested in-service stack.
//
// Ports:
//   clk         system clock
//   rst         synchronous, active-low reset
//   irq_in      raw interrupt lines (one per source)
//   reg_we      register write strobe
//   reg_addr    register word address
//   reg_wdata   register write data
//   reg_rdata   register read data, combinational from reg_addr
//   irq_req     interrupt request to the core
//   irq_id      winning source index
//   irq_vector  VEC_BASE + irq_id * VEC_STRIDE
//   irq_ack     core accepts the presented interrupt
//   iret        core returns from the current handler
//   nest_level  current in-service stack depth
//
// Register map: 0 ENABLE, 1 EDGE_SEL, 2 PENDING (W1C on edge sources), 3 CTRL,
// 4..7 PRIO nibbles (8 sources per word), 8 STATUS {iret_err, cur_prio, nest_level}.
module prio_vectored_intc #(
    parameter int unsigned NUM_SRC    = 8,
    parameter int unsigned PRIO_W     = 2,
    parameter int unsigned NEST_DEPTH = 4,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter int unsigned VEC_STRIDE = 4,
    localparam int unsigned ID_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic               reg_we,
    input  logic [3:0]         reg_addr,
    input  logic [31:0]        reg_wdata,
    output logic [31:0]        reg_rdata,
    output logic               irq_req,
    output logic [ID_W-1:0]    irq_id,
    output logic [31:0]        irq_vector,
    input  logic               irq_ack,
    input  logic               iret,
    output logic [3:0]         nest_level
);

    logic [NUM_SRC-1:0] irq_s_q, prev_q, enable_q, edge_sel_q, pend_q, pend_d;
    logic               ctrl_en_q;
    logic [PRIO_W-1:0]  prio_q [NUM_SRC];
    logic [ID_W-1:0]    stk_id_q [NEST_DEPTH];
    logic [PRIO_W-1:0]  stk_prio_q [NEST_DEPTH];
    logic [3:0]         nest_q;
    logic               iret_err_q;
    logic               irq_req_q;
    logic [ID_W-1:0]    irq_id_q;
    logic [31:0]        irq_vector_q;
    logic [PRIO_W-1:0]  req_prio_q;

    logic [NUM_SRC-1:0] pending, cand, rise, w1c, ack_clr;
    logic [PRIO_W-1:0]  top_prio, best_prio;
    logic [ID_W-1:0]    win_id;
    logic               found, eligible, accept, pop, push;
    logic [3:0]         push_lvl;

    // Level sources follow the synchronised line; edge sources use the latched bit.
    assign rise    = irq_s_q & ~prev_q;
    assign pending = (edge_sel_q & pend_q) | (~edge_sel_q & irq_s_q);
    assign cand    = pending & enable_q & {NUM_SRC{ctrl_en_q}};
    assign w1c     = (reg_we && reg_addr == 4'd2) ? reg_wdata[NUM_SRC-1:0] : '0;

    assign accept   = irq_ack & irq_req_q;
    assign pop      = iret & (nest_q != 4'd0);
    // Pop frees a slot first, so a combined ack+iret can push even at full depth.
    assign push     = accept & (pop | (nest_q != 4'(NEST_DEPTH)));
    assign push_lvl = nest_q - 4'(pop);

    always_comb begin
        top_prio = '0;
        for (int k = 0; k < NEST_DEPTH; k++) begin
            if (nest_q == 4'(k + 1)) top_prio = stk_prio_q[k];
        end
    end

    // Ascending scan with strict compare keeps the lowest index on priority ties.
    always_comb begin
        found     = 1'b0;
        best_prio = '0;
        win_id    = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (cand[i] && (!found || prio_q[i] > best_prio)) begin
                found     = 1'b1;
                best_prio = prio_q[i];
                win_id    = ID_W'(i);
            end
        end
        eligible = found && (nest_q != 4'(NEST_DEPTH)) &&
                   ((nest_q == 4'd0) || (best_prio > top_prio));
    end

    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (accept && irq_id_q == ID_W'(i)) ack_clr[i] = edge_sel_q[i];
        end
        // A new edge beats a same-cycle clear.
        pend_d = edge_sel_q & (rise | (pend_q & ~w1c & ~ack_clr));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            irq_s_q      <= '0;
            prev_q       <= '0;
            enable_q     <= '0;
            edge_sel_q   <= '0;
            pend_q       <= '0;
            ctrl_en_q    <= 1'b0;
            nest_q       <= '0;
            iret_err_q   <= 1'b0;
            irq_req_q    <= 1'b0;
            irq_id_q     <= '0;
            irq_vector_q <= '0;
            req_prio_q   <= '0;
            for (int i = 0; i < NUM_SRC; i++) prio_q[i] <= '0;
            for (int k = 0; k < NEST_DEPTH; k++) begin
                stk_id_q[k]   <= '0;
                stk_prio_q[k] <= '0;
            end
        end else begin
            irq_s_q <= irq_in;
            prev_q  <= irq_s_q;
            pend_q  <= pend_d;

            if (reg_we && reg_addr == 4'd0) enable_q   <= reg_wdata[NUM_SRC-1:0];
            if (reg_we && reg_addr == 4'd1) edge_sel_q <= reg_wdata[NUM_SRC-1:0];
            if (reg_we && reg_addr == 4'd3) ctrl_en_q  <= reg_wdata[0];
            for (int i = 0; i < NUM_SRC; i++) begin
                if (reg_we && reg_addr == 4'(4 + i / 8)) begin
                    prio_q[i] <= reg_wdata[(i % 8) * 4 +: PRIO_W];
                end
            end

            if (iret && nest_q == 4'd0) begin
                iret_err_q <= 1'b1;
            end else if (reg_we && reg_addr == 4'd8 && reg_wdata[8]) begin
                iret_err_q <= 1'b0;
            end

            for (int k = 0; k < NEST_DEPTH; k++) begin
                if (push && push_lvl == 4'(k)) begin
                    stk_id_q[k]   <= irq_id_q;
                    stk_prio_q[k] <= req_prio_q;
                end
            end
            nest_q <= nest_q - 4'(pop) + 4'(push);

            // The acked request drops for one cycle so arbitration sees the new stack top.
            irq_req_q <= eligible & ~accept;
            if (eligible && !accept) begin
                irq_id_q     <= win_id;
                irq_vector_q <= VEC_BASE + 32'(win_id) * 32'(VEC_STRIDE);
                req_prio_q   <= best_prio;
            end
        end
    end

    always_comb begin
        reg_rdata = '0;
        unique case (reg_addr)
            4'd0: reg_rdata = 32'(enable_q);
            4'd1: reg_rdata = 32'(edge_sel_q);
            4'd2: reg_rdata = 32'(pending);
            4'd3: reg_rdata = {31'd0, ctrl_en_q};
            4'd8: reg_rdata = {23'd0, iret_err_q, 4'(top_prio), nest_q};
            default: begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (reg_addr == 4'(4 + i / 8)) reg_rdata[(i % 8) * 4 +: PRIO_W] = prio_q[i];
                end
            end
        endcase
    end

    // Stacked ids have no read path; they are kept for debug probing only.
    logic unused_bits;
    always_comb begin
        unused_bits = ^reg_wdata;
        for (int k = 0; k < NEST_DEPTH; k++) unused_bits = unused_bits ^ (^stk_id_q[k]);
    end

    assign irq_req    = irq_req_q;
    assign irq_id     = irq_id_q;
    assign irq_vector = irq_vector_q;
    assign nest_level = nest_q;

endmodule

// File: tb/tb_prio_vectored_intc.sv
module tb_prio_vectored_intc;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq_in;
    logic        reg_we;
    logic [3:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic        irq_req;
    logic [2:0]  irq_id;
    logic [31:0] irq_vector;
    logic        irq_ack;
    logic        iret;
    logic [3:0]  nest_level;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    prio_vectored_intc dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .reg_we     (reg_we),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_rdata  (reg_rdata),
        .irq_req    (irq_req),
        .irq_id     (irq_id),
        .irq_vector (irq_vector),
        .irq_ack    (irq_ack),
        .iret       (iret),
        .nest_level (nest_level)
    );

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } reg_vec_t;

    typedef struct {
        int id;
        int prio;
    } ent_t;

    // Reference model state (random phase)
    bit   ms [8];
    bit   mp [8];
    bit   mpend [8];
    ent_t stk [$];
    bit   mreq;
    int   mid;
    int   mreq_prio;
    logic [31:0] mvec;
    logic [7:0]  men, medge;
    int   mprio [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        reg_we    = 1'b1;
        reg_addr  = a;
        reg_wdata = d;
        tick();
        reg_we    = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
        reg_addr = a;
        #1;
        chk(name, reg_rdata, exp);
    endtask

    task automatic do_reset();
        rst = 1'b0; irq_in = '0; reg_we = 1'b0; reg_addr = '0; reg_wdata = '0;
        irq_ack = 1'b0; iret = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    task automatic pulse_iret();
        iret = 1'b1;
        tick();
        iret = 1'b0;
    endtask

    // One clock of the behavioural model, using the inputs about to be sampled.
    task automatic model_step();
        int  best = -1;
        int  win  = 0;
        bit  elig, acc;
        for (int p = 3; p >= 0 && best < 0; p--) begin
            for (int i = 0; i < 8; i++) begin
                if (best < 0 && men[i] && (medge[i] ? mpend[i] : ms[i]) && mprio[i] == p) begin
                    best = p;
                    win  = i;
                end
            end
        end
        elig = (best >= 0) && (stk.size() < 4) &&
               (stk.size() == 0 || best > stk[stk.size()-1].prio);
        acc = irq_ack && mreq;
        if (iret && stk.size() > 0) void'(stk.pop_back());
        if (acc) stk.push_back('{id: mid, prio: mreq_prio});
        for (int i = 0; i < 8; i++) begin
            if (medge[i]) mpend[i] = (ms[i] && !mp[i]) || (mpend[i] && !(acc && mid == i));
            else mpend[i] = 1'b0;
        end
        mreq = elig && !acc;
        if (elig && !acc) begin
            mid       = win;
            mreq_prio = best;
            mvec      = 32'h100 + 32'(win * 4);
        end
        for (int i = 0; i < 8; i++) begin
            mp[i] = ms[i];
            ms[i] = irq_in[i];
        end
    endtask

    reg_vec_t rv [10];

    initial begin
        rv[0] = '{addr: 4'd0,  wdata: 32'hFFFF_FFA5, exp: 32'h0000_00A5};
        rv[1] = '{addr: 4'd1,  wdata: 32'h0000_003C, exp: 32'h0000_003C};
        rv[2] = '{addr: 4'd3,  wdata: 32'hFFFF_FFFF, exp: 32'h0000_0001};
        rv[3] = '{addr: 4'd4,  wdata: 32'hFFFF_FFFF, exp: 32'h3333_3333};
        rv[4] = '{addr: 4'd4,  wdata: 32'h7654_3210, exp: 32'h3210_3210};
        rv[5] = '{addr: 4'd5,  wdata: 32'h1234_5678, exp: 32'h0000_0000};
        rv[6] = '{addr: 4'd9,  wdata: 32'hFFFF_FFFF, exp: 32'h0000_0000};
        rv[7] = '{addr: 4'd15, wdata: 32'h0000_0001, exp: 32'h0000_0000};
        rv[8] = '{addr: 4'd2,  wdata: 32'hFFFF_FFFF, exp: 32'h0000_0000};
        rv[9] = '{addr: 4'd8,  wdata: 32'h0000_0000, exp: 32'h0000_0000};

        // Reset state
        do_reset();
        chk("rst_req", 32'(irq_req), 32'd0);
        chk("rst_id", 32'(irq_id), 32'd0);
        chk("rst_vec", irq_vector, 32'd0);
        chk("rst_nest", 32'(nest_level), 32'd0);
        for (int a = 0; a < 9; a++) rd_chk("rst_reg", 4'(a), 32'd0);

        // Register map table
        foreach (rv[i]) begin
            wr(rv[i].addr, rv[i].wdata);
            rd_chk($sformatf("reg_tbl[%0d]", i), rv[i].addr, rv[i].exp);
        end

        // Edge source latency and vector
        do_reset();
        wr(4'd0, 32'h04); wr(4'd1, 32'h04); wr(4'd4, 32'h0000_0100); wr(4'd3, 32'h1);
        irq_in[2] = 1'b1;
        tick(); tick();
        chk("edge_lat2_req", 32'(irq_req), 32'd0);
        tick();
        chk("edge_lat3_req", 32'(irq_req), 32'd1);
        chk("edge_id", 32'(irq_id), 32'd2);
        chk("edge_vec", irq_vector, 32'h108);
        irq_in[2] = 1'b0;
        pulse_ack();
        chk("ack1_nest", 32'(nest_level), 32'd1);
        chk("ack1_req", 32'(irq_req), 32'd0);
        rd_chk("ack1_status", 4'd8, 32'h011);

        // Level source preemption
        wr(4'd0, 32'h24); wr(4'd4, 32'h0030_0100);
        irq_in[5] = 1'b1;
        tick();
        chk("lvl_lat1_req", 32'(irq_req), 32'd0);
        tick();
        chk("lvl_lat2_req", 32'(irq_req), 32'd1);
        chk("pre_id", 32'(irq_id), 32'd5);
        chk("pre_vec", irq_vector, 32'h114);
        pulse_ack();
        chk("pre_nest", 32'(nest_level), 32'd2);
        rd_chk("pre_status", 4'd8, 32'h032);
        tick(); tick(); tick();
        chk("lvl_no_rereq", 32'(irq_req), 32'd0);
        irq_in[5] = 1'b0;
        tick(); tick();
        pulse_iret();
        chk("iret_nest", 32'(nest_level), 32'd1);

        // Equal-priority tie and blocking
        do_reset();
        wr(4'd0, 32'h42); wr(4'd4, 32'h0200_0020); wr(4'd3, 32'h1);
        irq_in = 8'h42;
        tick(); tick();
        chk("tie_req", 32'(irq_req), 32'd1);
        chk("tie_id", 32'(irq_id), 32'd1);
        pulse_ack();
        tick(); tick(); tick();
        chk("tie_blocked", 32'(irq_req), 32'd0);
        irq_in = 8'h40;
        tick();
        pulse_iret();
        chk("tie_iret_req", 32'(irq_req), 32'd0);
        tick();
        chk("tie_second_req", 32'(irq_req), 32'd1);
        chk("tie_second_id", 32'(irq_id), 32'd6);
        chk("tie_second_vec", irq_vector, 32'h118);

        // Full nesting depth and iret error
        do_reset();
        wr(4'd0, 32'h1F); wr(4'd4, 32'h0003_3210); wr(4'd3, 32'h1);
        for (int k = 0; k < 4; k++) begin
            irq_in[k] = 1'b1;
            tick(); tick();
            chk($sformatf("nest_req[%0d]", k), 32'(irq_req), 32'd1);
            chk($sformatf("nest_id[%0d]", k), 32'(irq_id), 32'(k));
            pulse_ack();
            chk($sformatf("nest_lvl[%0d]", k), 32'(nest_level), 32'(k + 1));
        end
        irq_in[4] = 1'b1;
        tick(); tick(); tick();
        chk("full_no_req", 32'(irq_req), 32'd0);
        rd_chk("full_status", 4'd8, 32'h034);
        irq_in = '0;
        tick(); tick();
        for (int k = 0; k < 4; k++) pulse_iret();
        chk("unwind_nest", 32'(nest_level), 32'd0);
        pulse_iret();
        rd_chk("iret_err_set", 4'd8, 32'h100);
        wr(4'd8, 32'h100);
        rd_chk("iret_err_clr", 4'd8, 32'h000);

        // Pending on disabled edge source; set beats W1C
        do_reset();
        wr(4'd1, 32'h08); wr(4'd3, 32'h1);
        irq_in[3] = 1'b1;
        tick(); tick();
        rd_chk("dis_pend", 4'd2, 32'h08);
        chk("dis_no_req", 32'(irq_req), 32'd0);
        irq_in[3] = 1'b0;
        tick(); tick();
        irq_in[3] = 1'b1;
        tick();
        wr(4'd2, 32'h08);
        rd_chk("set_wins", 4'd2, 32'h08);
        irq_in[3] = 1'b0;
        wr(4'd2, 32'h08);
        rd_chk("w1c_clears", 4'd2, 32'h00);

        // Same-cycle ack and iret, then reset mid-handler
        do_reset();
        wr(4'd0, 32'h81); wr(4'd4, 32'h2000_0001); wr(4'd3, 32'h1);
        irq_in = 8'h01;
        tick(); tick();
        pulse_ack();
        irq_in = 8'h81;
        tick(); tick();
        chk("swap_req", 32'(irq_req), 32'd1);
        chk("swap_req_id", 32'(irq_id), 32'd7);
        irq_ack = 1'b1; iret = 1'b1;
        tick();
        irq_ack = 1'b0; iret = 1'b0;
        chk("swap_nest", 32'(nest_level), 32'd1);
        chk("swap_top_id", 32'(irq_id), 32'd7);
        rd_chk("swap_status", 4'd8, 32'h021);
        rst = 1'b0;
        tick();
        chk("midrst_nest", 32'(nest_level), 32'd0);
        chk("midrst_req", 32'(irq_req), 32'd0);
        rst = 1'b1;

        // Randomised run against the behavioural model
        do_reset();
        men   = 8'($urandom_range(0, 255)) | 8'h01;
        medge = 8'($urandom_range(0, 255));
        for (int i = 0; i < 8; i++) mprio[i] = $urandom_range(0, 3);
        wr(4'd0, 32'(men));
        wr(4'd1, 32'(medge));
        begin
            logic [31:0] pw = '0;
            for (int i = 0; i < 8; i++) pw[i*4 +: 4] = 4'(mprio[i]);
            wr(4'd4, pw);
        end
        wr(4'd3, 32'h1);
        for (int i = 0; i < 8; i++) begin
            ms[i] = 1'b0; mp[i] = 1'b0; mpend[i] = 1'b0;
        end
        stk.delete();
        mreq = 1'b0; mid = 0; mreq_prio = 0; mvec = '0;
        for (int c = 0; c < 300; c++) begin
            irq_in  = 8'($urandom & $urandom & $urandom);
            irq_ack = 1'($urandom_range(0, 1));
            iret    = ($urandom_range(0, 7) == 0);
            model_step();
            tick();
            chk("rnd_req", 32'(irq_req), 32'(mreq));
            chk("rnd_id", 32'(irq_id), 32'(mid));
            chk("rnd_vec", irq_vector, mvec);
            chk("rnd_nest", 32'(nest_level), 32'(stk.size()));
        end
        irq_ack = 1'b0; iret = 1'b0; irq_in = '0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/prio_vectored_intc.md
Name: prio_vectored_intc

Overview:
Parametrised successor to the core's fixed interrupt controller, sitting between peripheral interrupt lines and the processor's interrupt/IRET path. It supports NUM_SRC sources with per-source enable, per-source edge/level select and programmable priority. Its nested in-service stack allows strict-priority preemption up to NEST_DEPTH levels. It also presents a vector address to the core through a request/acknowledge handshake.

Parameters:
NUM_SRC, 8, number of interrupt sources, 1..32.
PRIO_W, 2, priority field width, 1..4; a larger value means higher priority.
NEST_DEPTH, 4, maximum nesting depth of the in-service stack, 1..8.
VEC_BASE, 32'h0000_0100, vector address of source 0.
VEC_STRIDE, 4, byte spacing between consecutive source vectors.

Ports:
clk  in  1  system clock; single clock domain.
rst  in  1  synchronous, active-low reset.
irq_in  in  NUM_SRC  raw interrupt lines from peripherals.
reg_we  in  1  register write strobe.
reg_addr  in  4  register word address.
reg_wdata  in  32  register write data.
reg_rdata  out  32  register read data; combinational from reg_addr.
irq_req  out  1  interrupt request to the core.
irq_id  out  ID_W  winning source index; ID_W = max(1, clog2(NUM_SRC)).
irq_vector  out  32  VEC_BASE + irq_id*VEC_STRIDE.
irq_ack  in  1  core accepts the presented interrupt.
iret  in  1  core returns from the current handler.
nest_level  out  4  current stack depth.

Behaviour:
Reset (rst==0 at a clk edge):
- All registers are cleared, the stack is emptied and the sync flops are cleared.
- irq_req=0, irq_id=0, irq_vector=0, nest_level=0.

Register map (word addresses; unmapped addresses read 0 and ignore writes):
- 0 ENABLE: one bit per source.
- 1 EDGE_SEL: 1 = rising-edge source, 0 = level source.
- 2 PENDING: read returns pending bits. Writing 1 clears an edge-source bit; writes to level-source bits have no effect.
- 3 CTRL: bit0 = global enable.
- 4..7 PRIO: one nibble per source. Word 4+k holds sources 8k..8k+7; only the low PRIO_W bits of each nibble are stored.
- 8 STATUS (read): [3:0] nest_level, [7:4] current priority, [8] iret_err (sticky). Writing 1 to bit8 clears iret_err.

Input path:
- irq_in passes through one sync flop (irq_s) and a prev flop.
- Edge source: pending is set on irq_s & ~prev. Pending latches even when the source is disabled.
- Level source: pending equals irq_s.
- If a new edge and a W1C write hit the same bit in the same cycle, the set wins.

Arbitration (every cycle, result registered):
- Candidates are pending & ENABLE, and only when CTRL[0]=1.
- The winner has the highest priority; ties go to the lowest index.
- The winner is eligible if nest_level==0, or if its priority is strictly greater than the priority at the top of the stack.
- Nothing is eligible while nest_level==NEST_DEPTH.
- irq_req, irq_id and irq_vector register the eligible winner. With no eligible winner, irq_req=0 and irq_id/irq_vector hold their last values.

Latency from irq_in rising edge to irq_req high:
- Edge source: 3 clk.
- Level source: 2 clk.

Acknowledge (irq_ack & irq_req at an edge):
- Push {irq_id, priority} onto the stack and increment nest_level.
- Clear the pending bit if the source is edge-type.
- irq_req is forced 0 on the following cycle.
- irq_ack while irq_req==0 is ignored.

Return:
- iret with nest_level>0 pops the stack and decrements nest_level.
- iret with nest_level==0 is ignored and sets iret_err.

Simultaneous irq_ack and iret:
- Pop first, then push; net nest_level is unchanged and the top entry is replaced.

Other rules:
- A level source that stays asserted does not re-request while it is in service, because equal priority does not preempt.
- Changing ENABLE, PRIO or EDGE_SEL never alters stack contents; it only affects subsequent arbitration.
- Reset asserted mid-handler empties the stack immediately.

Test Plan:
- Reset, then ENABLE=0x04, EDGE_SEL=0x04, PRIO src2=1, CTRL=1; pulse irq_in[2] -> irq_req=1 exactly 3 clk later, irq_id=2, irq_vector=0x108.
- Source 2 in service at priority 1; raise level source 5 at priority 3 -> preempting request id=5. Ack it -> nest_level=2, STATUS[7:4]=3. iret -> nest_level=1.
- Sources 1 and 6 both pending at priority 2, level 0 -> id=1 first; after ack, source 6 is blocked (equal priority) until iret.
- NEST_DEPTH=4 with four nested acks at priorities 0..3 -> no further irq_req even with a pending priority-3 source. An extra iret at level 0 -> STATUS[8]=1, and writing 0x100 to STATUS clears it.
- Edge pending on disabled source 3; write PENDING=0x08 in the same cycle as a new edge -> bit stays 1. Separate write -> bit clears.
- Same-cycle irq_ack and iret at level 1 -> nest_level stays 1 and the top id equals the acked source. Assert rst=0 mid-handler -> nest_level=0, irq_req=0 next clk.
